// File: rtl/mips_mc_ctrl_pkg.sv
// Shared MIPS control definitions: instruction fields, ALU operations,
// multicycle FSM states, mux encodings and the registered control word.
package mips_mc_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned STATE_W  = 4;

  typedef enum logic [OP_W-1:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDI  = 6'h08,
    LW    = 6'h23,
    SW    = 6'h2b
  } OpCode;

  typedef enum logic [FUNCT_W-1:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25
  } Funct;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } op_code;

  typedef enum logic [STATE_W-1:0] {
    INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  } CtrlState;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } AluSrcB;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } PcSrc;

  // State-decoded control word; pc_en/retire here are the unconditional parts only.
  typedef struct packed {
    logic   iord;
    logic   mem_read;
    logic   mem_write;
    logic   reg_dst;
    logic   mem_to_reg;
    logic   reg_write;
    logic   alu_src_a;
    AluSrcB alu_src_b;
    op_code alu_op;
    PcSrc   pc_src;
    logic   pc_en;
    logic   retire;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decode: ALU operation and legality of the funct field.
module mips_alu_dec
  import mips_mc_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output op_code             alu_op_c,
  output logic               funct_legal_c
);

  always_comb begin
    alu_op_c      = ALU_ADD;
    funct_legal_c = 1'b1;
    case (funct)
      FN_ADD:  alu_op_c = ALU_ADD;
      FN_SUB:  alu_op_c = ALU_SUB;
      FN_AND:  alu_op_c = ALU_AND;
      FN_OR:   alu_op_c = ALU_OR;
      default: funct_legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM with memory-ready handshake,
// access timeout, illegal-instruction trap and retired-instruction counter.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          BNE_EN      = 1'b1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_W-1:0]      opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic [1:0]           pc_src,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] retired_cnt,
  output logic                 illegal,
  output logic                 bus_err
);

  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam int unsigned WAIT_W     = TIMEOUT_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST    = TIMEOUT_EN ? MEM_TIMEOUT - 1 : 0;

  CtrlState          state, state_next;
  ctrl_t             ctrl_q, ctrl_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_sw, is_bne;
  op_code            alu_fn_c;
  logic              funct_legal_c;
  logic              mem_state_c, wait_to_c, illegal_set_c, timeout_set_c;
  logic              retire_c, branch_take_c;

  mips_alu_dec u_alu_dec (
    .funct         (funct),
    .alu_op_c      (alu_fn_c),
    .funct_legal_c (funct_legal_c)
  );

  assign mem_state_c = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  // The MEM_TIMEOUT-th consecutive not-ready cycle traps; a ready in that cycle wins.
  assign wait_to_c   = TIMEOUT_EN && !mem_ready && (wait_cnt == WAIT_W'(TO_LAST));

  always_comb begin
    state_next    = state;
    illegal_set_c = 1'b0;
    timeout_set_c = 1'b0;
    case (state)
      INIT:   state_next = FETCH;
      FETCH: begin
        if (mem_ready)      state_next = DECODE;
        else if (wait_to_c) begin state_next = HALT; timeout_set_c = 1'b1; end
      end
      DECODE: begin
        case (opcode)
          LW, SW:  state_next = MEMADR;
          RTYPE:   state_next = funct_legal_c ? EXEC : HALT;
          ADDI:    state_next = ADDIEX;
          BEQ:     state_next = BRANCH;
          BNE:     state_next = BNE_EN ? BRANCH : HALT;
          J:       state_next = JUMP;
          default: state_next = HALT;
        endcase
        illegal_set_c = (state_next == HALT);
      end
      MEMADR: state_next = is_sw ? MEMWR : MEMRD;
      MEMRD: begin
        if (mem_ready)      state_next = MEMWB;
        else if (wait_to_c) begin state_next = HALT; timeout_set_c = 1'b1; end
      end
      MEMWR: begin
        if (mem_ready)      state_next = FETCH;
        else if (wait_to_c) begin state_next = HALT; timeout_set_c = 1'b1; end
      end
      EXEC:   state_next = ALUWB;
      ADDIEX: state_next = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_next = FETCH;
      HALT:   state_next = HALT;
      default: state_next = INIT;
    endcase
  end

  // Control word for the state being entered, registered alongside the state.
  always_comb begin
    ctrl_d        = '0;
    ctrl_d.alu_op = ALU_ADD;
    case (state_next)
      FETCH:  begin ctrl_d.mem_read = 1'b1; ctrl_d.alu_src_b = SRCB_FOUR; ctrl_d.pc_src = PC_ALU; end
      DECODE: ctrl_d.alu_src_b = SRCB_IMM_SH2;
      MEMADR: begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_src_b = SRCB_IMM; end
      MEMRD:  begin ctrl_d.mem_read = 1'b1; ctrl_d.iord = 1'b1; end
      MEMWB:  begin ctrl_d.reg_write = 1'b1; ctrl_d.mem_to_reg = 1'b1; ctrl_d.retire = 1'b1; end
      MEMWR:  begin ctrl_d.mem_write = 1'b1; ctrl_d.iord = 1'b1; end
      EXEC:   begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_src_b = SRCB_REG; ctrl_d.alu_op = alu_fn_c; end
      ALUWB:  begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.retire = 1'b1; end
      ADDIEX: begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_src_b = SRCB_IMM; ctrl_d.alu_op = ALU_ADD; end
      ADDIWB: begin ctrl_d.reg_write = 1'b1; ctrl_d.retire = 1'b1; end
      BRANCH: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_REG;
        ctrl_d.alu_op    = ALU_SUB;
        ctrl_d.pc_src    = PC_ALUOUT;
        ctrl_d.retire    = 1'b1;
      end
      JUMP:   begin ctrl_d.pc_src = PC_JUMP; ctrl_d.pc_en = 1'b1; ctrl_d.retire = 1'b1; end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      ctrl_q      <= '0;
      wait_cnt    <= '0;
      is_sw       <= 1'b0;
      is_bne      <= 1'b0;
      retired_cnt <= '0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state    <= state_next;
      ctrl_q   <= ctrl_d;
      wait_cnt <= (TIMEOUT_EN && mem_state_c && !mem_ready && (state_next == state))
                  ? wait_cnt + WAIT_W'(1) : '0;
      if (state == DECODE) begin
        is_sw  <= (opcode == SW);
        is_bne <= (opcode == BNE);
      end
      if (retire_c)      retired_cnt <= retired_cnt + CNT_WIDTH'(1);
      if (illegal_set_c) illegal     <= 1'b1;
      if (timeout_set_c) bus_err     <= 1'b1;
    end
  end

  // Handshake- and flag-qualified outputs depend on this cycle's inputs.
  assign branch_take_c = is_bne ? !zero : zero;
  assign retire_c      = ctrl_q.retire || ((state == MEMWR) && mem_ready);
  assign retire        = retire_c;
  assign pc_en         = ctrl_q.pc_en || ((state == FETCH) && mem_ready)
                         || ((state == BRANCH) && branch_take_c);
  assign ir_write      = (state == FETCH) && mem_ready;

  assign iord       = ctrl_q.iord;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign pc_src     = ctrl_q.pc_src;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench: an instruction-level model expands each instruction into
// per-cycle expected control words; a negedge monitor compares them.
`timescale 1ns/1ps
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic retire;
    logic [15:0] cnt;
    logic illegal, bus_err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n_a, rst_n_b, zero, mem_ready;
  logic [5:0] opcode, funct;

  logic a_pc_en, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg, a_reg_write;
  logic a_alu_src_a, a_retire, a_illegal, a_bus_err;
  logic [1:0] a_alu_src_b, a_alu_op, a_pc_src, a_retired_cnt;
  logic b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg, b_reg_write;
  logic b_alu_src_a, b_retire, b_illegal, b_bus_err;
  logic [1:0] b_alu_src_b, b_alu_op, b_pc_src;
  logic [15:0] b_retired_cnt;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_TIMEOUT(4), .BNE_EN(1'b1), .CNT_WIDTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(a_pc_en), .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .pc_src(a_pc_src),
    .retire(a_retire), .retired_cnt(a_retired_cnt), .illegal(a_illegal), .bus_err(a_bus_err));

  mips_mc_ctrl #(.MEM_TIMEOUT(0), .BNE_EN(1'b0), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(b_pc_en), .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .pc_src(b_pc_src),
    .retire(b_retire), .retired_cnt(b_retired_cnt), .illegal(b_illegal), .bus_err(b_bus_err));

  obs_t obs_a, obs_b;
  assign obs_a = {a_pc_en, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg,
                  a_reg_write, a_alu_src_a, a_alu_src_b, a_alu_op, a_pc_src, a_retire,
                  14'd0, a_retired_cnt, a_illegal, a_bus_err};
  assign obs_b = {b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg,
                  b_reg_write, b_alu_src_a, b_alu_src_b, b_alu_op, b_pc_src, b_retire,
                  b_retired_cnt, b_illegal, b_bus_err};

  // Model configuration and architectural state
  bit   sel_b = 1'b0;
  int   tmo;
  bit   bne_en;
  int   cw_mask;
  bit   illegal_m, bus_err_m, halted;
  int   cnt_m;
  obs_t exp_q[$];
  string tag_q[$];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    obs_t e, o;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = sel_b ? obs_b : obs_a;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s (cfg %0d, t=%0t): got %h expected %h", t, sel_b, $time, o, e);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t w();
    obs_t e;
    e = '0;
    e.cnt = 16'(cnt_m);
    e.illegal = illegal_m;
    e.bus_err = bus_err_m;
    return e;
  endfunction

  function automatic bit fn_ok(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25);
  endfunction

  function automatic logic [1:0] fn_op(input logic [5:0] fn);
    case (fn)
      6'h22:   return 2'd1;
      6'h24:   return 2'd2;
      6'h25:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic bit op_ok(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:                             return fn_ok(fn);
      6'h02, 6'h04, 6'h08, 6'h23, 6'h2b: return 1'b1;
      6'h05:                             return bne_en;
      default:                           return 1'b0;
    endcase
  endfunction

  task automatic step(input obs_t e, input string t, input logic rdy, input logic z);
    mem_ready = rdy;
    zero = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    cnt_m = (cnt_m + 1) & cw_mask;
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic mem_wait(input int kind, input int waits, input bit abort, output bit ok);
    obs_t base, e;
    int n;
    bit tmo_hit;
    string t;
    base = w();
    case (kind)
      0:       begin base.mem_read = 1'b1; base.alu_src_b = 2'b01; t = "fetch"; end
      1:       begin base.mem_read = 1'b1; base.iord = 1'b1; t = "memrd"; end
      default: begin base.mem_write = 1'b1; base.iord = 1'b1; t = "memwr"; end
    endcase
    tmo_hit = (tmo != 0) && (waits >= tmo);
    n = tmo_hit ? tmo : waits;
    if (abort) n = 1;
    for (int i = 0; i < n; i++) step(base, {t, "_wait"}, 1'b0, rb());
    ok = 1'b0;
    if (abort) return;
    if (tmo_hit) begin bus_err_m = 1'b1; halted = 1'b1; return; end
    e = base;
    if (kind == 0) begin e.pc_en = 1'b1; e.ir_write = 1'b1; end
    if (kind == 2) e.retire = 1'b1;
    step(e, t, 1'b1, rb());
    if (kind == 2) bump();
    ok = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm, input bit abort);
    obs_t e;
    bit ok;
    opcode = op;
    funct = fn;
    mem_wait(0, wf, 1'b0, ok);
    if (!ok) return;
    e = w(); e.alu_src_b = 2'b11;
    step(e, "decode", rb(), rb());
    if (!op_ok(op, fn)) begin illegal_m = 1'b1; halted = 1'b1; return; end
    case (op)
      6'h00: begin
        e = w(); e.alu_src_a = 1'b1; e.alu_op = fn_op(fn);
        step(e, "exec", rb(), rb());
        e = w(); e.reg_write = 1'b1; e.reg_dst = 1'b1; e.retire = 1'b1;
        step(e, "aluwb", rb(), rb()); bump();
      end
      6'h08: begin
        e = w(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        step(e, "addiex", rb(), rb());
        e = w(); e.reg_write = 1'b1; e.retire = 1'b1;
        step(e, "addiwb", rb(), rb()); bump();
      end
      6'h04, 6'h05: begin
        e = w(); e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_src = 2'b01; e.retire = 1'b1;
        e.pc_en = (op == 6'h04) ? z : !z;
        step(e, "branch", rb(), z); bump();
      end
      6'h02: begin
        e = w(); e.pc_src = 2'b10; e.pc_en = 1'b1; e.retire = 1'b1;
        step(e, "jump", rb(), rb()); bump();
      end
      default: begin
        e = w(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        step(e, "memadr", rb(), rb());
        mem_wait((op == 6'h23) ? 1 : 2, wm, abort, ok);
        if (ok && op == 6'h23) begin
          e = w(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.retire = 1'b1;
          step(e, "memwb", rb(), rb()); bump();
        end
      end
    endcase
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom);
      funct = 6'($urandom);
      step(w(), "halt", rb(), rb());
    end
  endtask

  task automatic do_reset();
    if (sel_b) rst_n_b = 1'b0; else rst_n_a = 1'b0;
    illegal_m = 1'b0; bus_err_m = 1'b0; halted = 1'b0; cnt_m = 0;
    step(w(), "reset", rb(), rb());
    step(w(), "reset", rb(), rb());
    if (sel_b) rst_n_b = 1'b1; else rst_n_a = 1'b1;
    step(w(), "init", rb(), rb());
  endtask

  task automatic rand_instr();
    logic [5:0] op, fn;
    int r, wf, wm;
    r = $urandom_range(0, 24);
    if (r <= 5)       op = 6'h00;
    else if (r <= 7)  op = 6'h02;
    else if (r <= 10) op = 6'h04;
    else if (r <= 13) op = 6'h05;
    else if (r <= 15) op = 6'h08;
    else if (r <= 19) op = 6'h23;
    else if (r <= 23) op = 6'h2b;
    else              op = 6'($urandom);
    case ($urandom_range(0, 9))
      0:       fn = 6'($urandom);
      1, 2:    fn = 6'h22;
      3, 4:    fn = 6'h24;
      5, 6:    fn = 6'h25;
      default: fn = 6'h20;
    endcase
    wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
    wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : 0;
    run_instr(op, fn, rb(), wf, wm, 1'b0);
    if (halted) begin hold_halt(3); do_reset(); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // Config A: timeout 4, BNE decoded, 2-bit retire counter
    sel_b = 1'b0; tmo = 4; bne_en = 1'b1; cw_mask = 3;
    do_reset();
    run_instr(6'h00, 6'h22, 1'b0, 0, 0, 1'b0);
    if (a_retired_cnt !== 2'd1) begin
      errors++;
      $display("FAIL retired_cnt after first R-type: got %0d expected 1", a_retired_cnt);
    end
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b0, 0, 2, 1'b0);
    run_instr(6'h08, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
    run_instr(6'h00, 6'h24, 1'b0, 0, 0, 1'b0);
    run_instr(6'h00, 6'h25, 1'b0, 0, 0, 1'b0);
    run_instr(6'h00, 6'h20, 1'b0, 3, 0, 1'b0);
    run_instr(6'h00, 6'h20, 1'b0, 4, 0, 1'b0);
    hold_halt(10); do_reset();
    run_instr(6'h23, 6'h00, 1'b0, 0, 6, 1'b0);
    hold_halt(3); do_reset();
    run_instr(6'h2b, 6'h00, 1'b0, 0, 9, 1'b0);
    hold_halt(3); do_reset();
    run_instr(6'h3f, 6'h20, 1'b0, 0, 0, 1'b0);
    hold_halt(10); do_reset();
    run_instr(6'h00, 6'h27, 1'b0, 0, 0, 1'b0);
    hold_halt(10); do_reset();
    run_instr(6'h2b, 6'h00, 1'b0, 0, 3, 1'b1);
    do_reset();
    run_instr(6'h2b, 6'h00, 1'b0, 0, 0, 1'b0);
    repeat (300) rand_instr();

    // Config B: timeout disabled, BNE illegal, 16-bit retire counter
    rst_n_a = 1'b0;
    sel_b = 1'b1; tmo = 0; bne_en = 1'b0; cw_mask = 32'h0000_ffff;
    do_reset();
    run_instr(6'h05, 6'h00, 1'b0, 0, 0, 1'b0);
    hold_halt(10); do_reset();
    run_instr(6'h23, 6'h00, 1'b0, 20, 25, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b1, 7, 18, 1'b0);
    repeat (150) rand_instr();

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never compared", exp_q.size());
    end
    if (checks < 1000) begin
      errors++;
      $display("FAIL coverage: only %0d checks ran", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Parametrised multicycle control unit for the MIPS datapath. It is the successor to the single-cycle decode built on the shared `OpCode`/`Funct`/`op_code` types. A Moore FSM sequences fetch, decode, execute, memory and write-back. Memory accesses use a ready handshake with a timeout, and the unit traps on illegal opcode/funct. It sits between the instruction register fields and the datapath muxes and enables.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready in one memory state; 0 disables the timeout.
BNE_EN, 1, 1 = decode BNE (opcode 6'h05); 0 = BNE is illegal.
CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], type OpCode
funct  in  6  IR[5:0], type Funct
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_en  out  1  PC load enable (includes branch qualification)
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
alu_op  out  2  type op_code
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
retire  out  1  one-cycle pulse when an instruction completes
retired_cnt  out  CNT_WIDTH  count of retired instructions
illegal  out  1  sticky: illegal opcode or funct trapped
bus_err  out  1  sticky: memory timeout trapped

Behaviour:
- Reset (async, rst_n=0): state=INIT, all outputs 0, retired_cnt=0, wait counter=0. Deasserting reset mid-instruction aborts the instruction; no write enables are asserted until the next FETCH.
- Outputs are a pure decode of state. Exceptions: pc_en in FETCH and BRANCH, and ir_write in FETCH. Every output not listed for a state is 0. alu_op defaults to ALU_ADD.
- INIT: all outputs 0; next FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - If mem_ready, next DECODE; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11 (precompute branch target). Next state by opcode:
  - LW/SW -> MEMADR
  - RTYPE with a legal funct -> EXEC
  - ADDI -> ADDIEX
  - BEQ -> BRANCH
  - BNE (when BNE_EN) -> BRANCH
  - J -> JUMP
  - anything else -> HALT with illegal set
- MEMADR: alu_src_a=1, alu_src_b=10. Next MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Stay until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1; next FETCH.
- MEMWR: mem_write=1, iord=1. Stay until mem_ready, then retire=1 in that cycle and next FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. alu_op from funct: ADD->ALU_ADD, SUB->ALU_SUB, AND->ALU_AND, OR->ALU_OR. Next ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1; next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=ALU_ADD; next ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, retire=1; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=ALU_SUB, pc_src=01.
  - pc_en = zero for BEQ; pc_en = !zero for BNE.
  - retire=1; next FETCH.
- JUMP: pc_src=10, pc_en=1, retire=1; next FETCH.
- HALT: terminal; all enables 0; leave only via reset. illegal and bus_err hold their values.
- Wait counter:
  - Clears on entry to FETCH/MEMRD/MEMWR and whenever mem_ready=1.
  - Increments each cycle spent waiting.
  - When the count reaches MEM_TIMEOUT with mem_ready=0 (and MEM_TIMEOUT != 0): next HALT, bus_err=1.
  - mem_ready=1 in the same cycle as the timeout takes priority: the access completes normally.
- retired_cnt increments on retire and wraps modulo 2^CNT_WIDTH.
- Latency with mem_ready tied to 1, counted from FETCH through the retire cycle: R-type 4, ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles.
- opcode/funct are sampled only in DECODE and EXEC. The IR holds them stable after FETCH.

Decomposition:
- Add to the shared definitions package:
  - BNE = 6'h05 in OpCode
  - `CtrlState` enum: INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  - AluSrcB and PcSrc enums for the mux encodings
- One natural sub-module: mips_alu_dec, combinational funct -> op_code plus funct_legal. The FSM, wait counter and retire counter stay in mips_mc_ctrl.

Test Plan:
- Reset, mem_ready=1, opcode RTYPE funct SUB -> states INIT,FETCH,DECODE,EXEC,ALUWB. alu_op=ALU_SUB in EXEC. reg_write=1 and reg_dst=1 in ALUWB. retired_cnt=1.
- LW with mem_ready low for 3 cycles in MEMRD -> mem_read/iord held 3 extra cycles, then MEMWB with mem_to_reg=1. Total 8 cycles from FETCH to retire.
- Branches:
  - BEQ with zero=1 -> pc_en=1, pc_src=01 in BRANCH.
  - BEQ with zero=0 -> pc_en=0.
  - BNE (BNE_EN=1) with zero=0 -> pc_en=1.
- Illegal decodes:
  - opcode 6'h3f -> HALT, illegal=1, all enables 0 for 10 cycles.
  - RTYPE funct 6'h27 -> same response.
  - With BNE_EN=0, opcode 6'h05 -> same response.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles with bus_err=1. With mem_ready=1 on the 4th wait cycle instead -> normal DECODE, bus_err=0.
- Async reset asserted in MEMWR -> outputs 0 immediately, no mem_write after release, restart at INIT. CNT_WIDTH=2 with 5 retires -> retired_cnt=1.
